deser_collect: RTL
==================

DESER_COLLECT -- requirements
Module: deser_collect

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the word length in bits (legal range 2..32).
REQ-002 The block SHALL have port t_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port r, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port s_in, input, 1 bit: serial two's-complement data from the upstream complementer, LSB first.
REQ-005 The block SHALL have port s_vld, input, 1 bit: s_in carries a valid bit this cycle.
REQ-006 The block SHALL have port s_sof, input, 1 bit: start of frame, qualified by s_vld; marks bit 0 of a word.
REQ-007 The block SHALL have port p_data, output, WIDTH bits: the assembled word.
REQ-008 The block SHALL have port p_vld, output, 1 bit: p_data holds a valid word.
REQ-009 The block SHALL have port p_rdy, input, 1 bit: the consumer accepts the word when p_vld and p_rdy are both 1.
REQ-010 The block SHALL have port p_neg, output, 1 bit: equal to p_data[WIDTH-1] while p_vld is 1, else 0.
REQ-011 The block SHALL have port ovf, output, 1 bit: sticky flag, a word was dropped.
REQ-012 The block SHALL have port ferr, output, 1 bit: one-cycle pulse, a frame was restarted before completion.

Function
REQ-013 The state machine SHALL have states IDLE (waiting for sof) and SHIFT (collecting bits).
REQ-014 In IDLE, a bit with s_vld=1 and s_sof=0 SHALL be ignored.
REQ-015 In IDLE, a bit with s_vld=1 and s_sof=1 SHALL be stored as bit 0, set the bit count to 1 and move to SHIFT.
REQ-016 In SHIFT, each s_vld=1 bit SHALL be stored at position count, and count SHALL increment; cycles with s_vld=0 SHALL hold all state.
REQ-017 When bit WIDTH-1 is stored, the assembled word SHALL transfer to the output register and the FSM SHALL return to IDLE; p_vld SHALL rise on the next cycle (1-cycle latency from the sampling edge of the last bit).
REQ-018 In SHIFT, a bit with s_sof=1 SHALL restart the frame: the partial word is discarded, the bit is stored as bit 0, count is set to 1, and ferr pulses for one cycle.
REQ-019 The output register SHALL be a single-entry buffer: p_data and p_vld SHALL hold stable until the handshake completes.
REQ-020 When a word completes in the same cycle that the handshake completes, the new word SHALL load and p_vld SHALL stay 1 with no bubble.
REQ-021 When a word completes while p_vld=1 and p_rdy=0, the new word SHALL be dropped, the held word SHALL be kept, and ovf SHALL be set.
REQ-022 ovf SHALL remain set until reset.
REQ-023 The bit count SHALL be clog2(WIDTH)+1 bits wide and SHALL never exceed WIDTH-1 while in SHIFT.

Reset
REQ-024 While r=0, the block SHALL enter IDLE with count=0 and shift register=0.
REQ-025 While r=0, the outputs SHALL be p_data=0, p_vld=0, p_neg=0, ovf=0, ferr=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial word, and a held output word SHALL be lost.

Configuration
REQ-027 When macro DESER_PARITY_EN is defined, the block SHALL add output p_par (1 bit), the even parity (XOR) of p_data, registered with the word, and 0 at reset and when p_vld=0.
REQ-028 When DESER_PARITY_EN is undefined, p_par and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-029 A shared package deser_pkg SHALL hold the state enum (IDLE, SHIFT) and the constant DESER_WIDTH_DEF=8.
REQ-030 The output buffer SHALL be a sub-module deser_hold (single-entry valid/ready register), instantiated once.

Verification
REQ-031 After reset, drive WIDTH=8, sof with bits LSB-first of 0xF3, p_rdy=1 -> p_vld=1 for 1 cycle, one cycle after the 8th bit, p_data=0xF3, p_neg=1.
REQ-032 Insert s_vld=0 gaps between the bits of 0x05 -> p_data=0x05, p_neg=0, same completion rule.
REQ-033 Send 3 bits, then sof with 0x81 -> ferr pulses once, p_data=0x81.
REQ-034 Send 0x11 with p_rdy=0, then 0x22 -> p_data stays 0x11, ovf=1; then p_rdy=1 -> 0x11 accepted, ovf stays 1.
REQ-035 Send back-to-back words 0x0A and 0x0B with p_rdy=1 -> both delivered, no bubble at the handshake.
REQ-036 Pulse r low mid-frame and while p_vld=1 -> all outputs 0 immediately; the next full frame is delivered correctly. With DESER_PARITY_EN defined, 0xF3 -> p_par=0.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared state encoding and constants for the serial word collector.
// Optional parity output is enabled by defining DESER_PARITY_EN.
package deser_pkg;

    localparam int DESER_WIDTH_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

    // Counter must hold values 0..WIDTH-1 with one spare bit of headroom.
    function automatic int deser_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/deser_hold.sv
// Single-entry valid/ready output register; drops a word that arrives while
// full and not being drained. DESER_PARITY_EN adds a registered parity bit.
module deser_hold
    import deser_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_data,
    output logic             o_vld,
    output logic             o_neg,
`ifdef DESER_PARITY_EN
    output logic             o_par,
`endif
    output logic             o_ovf
);

    logic [WIDTH-1:0] r_data;
    logic             r_vld;
    logic             r_ovf;
    logic             w_take;
    logic             w_drop;

    // A drain on the same edge frees the slot, so a completing word never bubbles.
    assign w_take = i_load && (!r_vld || i_rdy);
    assign w_drop = i_load && r_vld && !i_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_vld  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_take) begin
                r_data <= i_data;
                r_vld  <= 1'b1;
            end else if (r_vld && i_rdy) begin
                r_vld  <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef DESER_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_take) begin
            r_par <= ^i_data;
        end
    end

    assign o_par = r_vld & r_par;
`endif

    assign o_data = r_data;
    assign o_vld  = r_vld;
    assign o_neg  = r_vld & r_data[WIDTH-1];
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/deser_collect.sv
// Collects LSB-first serial words framed by s_sof into a held parallel word.
// Defining DESER_PARITY_EN adds the p_par output.
//
//   state | meaning
//   IDLE  | waiting for a start-of-frame bit
//   SHIFT | collecting bits 1..WIDTH-1 of the current word
module deser_collect
    import deser_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEF
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             s_in,
    input  logic             s_vld,
    input  logic             s_sof,
    output logic [WIDTH-1:0] p_data,
    output logic             p_vld,
    input  logic             p_rdy,
    output logic             p_neg,
`ifdef DESER_PARITY_EN
    output logic             p_par,
`endif
    output logic             ovf,
    output logic             ferr
);

    localparam int            CW       = deser_cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    deser_state_t     r_state;
    deser_state_t     w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic             r_ferr;

    logic [WIDTH-1:0] w_bit;
    logic [WIDTH-1:0] w_word;
    logic             w_load;
    logic             w_restart;

    assign w_bit = {{(WIDTH-1){1'b0}}, s_in};

    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sreg  <= '0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sreg  <= w_sreg_nxt;
            r_ferr  <= w_restart;
        end
    end

    // Unwritten positions of r_sreg are always zero, so bits are merged by OR.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sreg_nxt  = r_sreg;
        case (r_state)
            IDLE: begin
                if (s_vld && s_sof) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = CNT_ONE;
                    w_sreg_nxt  = w_bit;
                end
            end
            SHIFT: begin
                if (s_vld) begin
                    if (s_sof) begin
                        w_cnt_nxt  = CNT_ONE;
                        w_sreg_nxt = w_bit;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                        w_sreg_nxt  = '0;
                    end else begin
                        w_cnt_nxt  = r_cnt + CNT_ONE;
                        w_sreg_nxt = r_sreg | (w_bit << r_cnt);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_sreg_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        w_word    = r_sreg | (w_bit << r_cnt);
        w_load    = 1'b0;
        w_restart = 1'b0;
        if (r_state == SHIFT && s_vld) begin
            w_restart = s_sof;
            w_load    = !s_sof && (r_cnt == CNT_LAST);
        end
    end

    deser_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk    (t_clk),
        .rst_n  (r),
        .i_load (w_load),
        .i_data (w_word),
        .i_rdy  (p_rdy),
        .o_data (p_data),
        .o_vld  (p_vld),
        .o_neg  (p_neg),
`ifdef DESER_PARITY_EN
        .o_par  (p_par),
`endif
        .o_ovf  (ovf)
    );

    assign ferr = r_ferr;

endmodule
